// File: rtl/fpga_input_reader_pkg.sv
// Shared definitions for the board I/O blocks: reader FSM states and BCD digit helpers.
// The HEX display driver reuses BCD_MAX and the digit checks.
package fpga_input_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ARM        = 3'd1,
      ST_WAIT_REL   = 3'd2,
      ST_WAIT_PRESS = 3'd3,
      ST_RESP       = 3'd4
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // tens*10 is built from shifts so no multiplier is inferred
   function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
      logic [6:0] t;
      t = {3'b000, tens};
      return (t << 3) + (t << 1) + {3'b000, units};
   endfunction

   function automatic logic bcd_invalid(input logic [3:0] tens, input logic [3:0] units);
      return (tens > BCD_MAX) || (units > BCD_MAX);
   endfunction

endpackage

// File: rtl/fpga_input_reader_key_debouncer.sv
// Confirm-key conditioning: 2-flop synchroniser, stability counter, debounced level
// (1 = pressed) and a 1-cycle press pulse on the released->pressed edge.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;
   logic          w_sync_pressed;

   assign w_sync_pressed = ~r_s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1    <= 1'b1;
         r_s2    <= 1'b1;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= key_n;
         r_s2    <= r_s1;
         r_press <= 1'b0;
         // the level flips on the Nth consecutive cycle of disagreement; any bounce restarts
         if (w_sync_pressed != r_level) begin
            if (r_cnt == CNT_LAST) begin
               r_level <= w_sync_pressed;
               r_press <= w_sync_pressed;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule

// File: rtl/fpga_input_reader.sv
// IN-instruction input reader: stalls the core until the user confirms the switch value,
// then returns it (BCD-decoded or raw) as a DATA_W word held while in_valid is high.
module fpga_input_reader
   import fpga_input_reader_pkg::*;
#(
   parameter int DATA_W          = 32,
   parameter int SW_W            = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BCD_MODE        = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_req,
   input  logic [SW_W-1:0]   sw,
   input  logic              key_n,
   output logic [DATA_W-1:0] in_data,
   output logic              in_valid,
   output logic              stall,
   output logic              waiting,
   output logic              bad_digit
);

   logic [SW_W-1:0]   r_sw_s1;
   logic [SW_W-1:0]   r_sw_s2;
   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_data;
   logic              r_bad;
   logic              w_key_level;
   logic              w_press;
   logic              w_capture;
   logic              w_reject;
   logic              w_digit_bad;
   logic [DATA_W-1:0] w_value;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .clk  (clk),
      .rst  (rst),
      .key_n(key_n),
      .level(w_key_level),
      .press(w_press)
   );

   assign w_digit_bad = (BCD_MODE != 0) && bcd_invalid(r_sw_s2[7:4], r_sw_s2[3:0]);
   assign w_value     = (BCD_MODE != 0) ? DATA_W'(bcd_to_bin(r_sw_s2[7:4], r_sw_s2[3:0]))
                                        : DATA_W'(r_sw_s2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sw_s1 <= '0;
         r_sw_s2 <= '0;
         r_state <= ST_IDLE;
         r_data  <= '0;
         r_bad   <= 1'b0;
      end else begin
         r_sw_s1 <= sw;
         r_sw_s2 <= r_sw_s1;
         r_state <= w_next;
         r_bad   <= w_reject;
         if (w_capture) begin
            r_data <= w_value;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_reject  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (in_req) w_next = ST_ARM;
         end
         ST_ARM: begin
            // a key still held from an earlier IN must be released before it can confirm
            if (!in_req)          w_next = ST_IDLE;
            else if (w_key_level) w_next = ST_WAIT_REL;
            else                  w_next = ST_WAIT_PRESS;
         end
         ST_WAIT_REL: begin
            if (!in_req)           w_next = ST_IDLE;
            else if (!w_key_level) w_next = ST_WAIT_PRESS;
         end
         ST_WAIT_PRESS: begin
            if (!in_req) begin
               w_next = ST_IDLE;
            end else if (w_press) begin
               if (w_digit_bad) begin
                  w_reject = 1'b1;
               end else begin
                  w_capture = 1'b1;
                  w_next    = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (!in_req) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign in_data   = r_data;
   assign in_valid  = (r_state == ST_RESP);
   assign stall     = in_req & ~in_valid;
   assign waiting   = (r_state == ST_ARM) || (r_state == ST_WAIT_REL) || (r_state == ST_WAIT_PRESS);
   assign bad_digit = r_bad;

endmodule
